// File: rtl/regwrite_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// source-0 destination select.
package regwrite_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regdst_e;

  // Core writeback destination: rt, rd, or $31 for link instructions.
  function automatic logic [4:0] wb_dest(input regdst_e sel, input logic [4:0] rt,
                                         input logic [4:0] rd);
    case (sel)
      REGDST_RD: return rd;
      REGDST_RA: return REG_RA;
      default:   return rt;
    endcase
  endfunction

endpackage

// File: rtl/regwrite_port_arbiter_wb_slot.sv
// One-entry writeback holding slot. Writes to $0 are accepted but
// discarded so they never reach the port or the pending mask.
module wb_slot
  import regwrite_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_take,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;
  logic              w_keep;

  // Draining and refilling in the same cycle keeps one write per cycle.
  assign o_ready  = rst_n && (!r_full || i_take);
  assign w_accept = i_valid && o_ready;
  assign w_keep   = (i_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= w_keep;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_keep) begin
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/regwrite_port_arbiter.sv
// Shares the register-file write port between core writeback (slot 0) and
// the multi-cycle unit (slot 1) with fixed priority plus starvation override.
module regwrite_port_arbiter
  import regwrite_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [ADDR_W-1:0]    in0_addr,
  input  logic [DATA_W-1:0]    in0_data,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [ADDR_W-1:0]    in1_addr,
  input  logic [DATA_W-1:0]    in1_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pending_mask
);

  localparam int CNT_W = 4;
  localparam int NREG  = 2**ADDR_W;

  logic              w_full0, w_full1;
  logic [ADDR_W-1:0] w_addr0, w_addr1;
  logic [DATA_W-1:0] w_data0, w_data1;
  logic              w_grant0, w_grant1;
  logic              w_starved;
  logic [CNT_W-1:0]  r_starve;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(in0_valid), .i_addr(in0_addr), .i_data(in0_data), .o_ready(in0_ready),
    .i_take(w_grant0),
    .o_full(w_full0), .o_addr(w_addr0), .o_data(w_data0)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(in1_valid), .i_addr(in1_addr), .i_data(in1_data), .o_ready(in1_ready),
    .i_take(w_grant1),
    .o_full(w_full1), .o_addr(w_addr1), .o_data(w_data1)
  );

  // Same-register conflicts always drain slot 0 first so slot 1's value lands last.
  assign w_starved = (r_starve == CNT_W'(STARVE_LIMIT)) && (w_addr0 != w_addr1);
  assign w_grant1  = !hold && w_full1 && (!w_full0 || w_starved);
  assign w_grant0  = !hold && w_full0 && !w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!hold) begin
      if (!w_full1 || w_grant1) begin
        r_starve <= '0;
      end else if (r_starve != CNT_W'(STARVE_LIMIT)) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= w_grant0 || w_grant1;
      if (w_grant1) begin
        wr_addr <= w_addr1;
        wr_data <= w_data1;
      end else if (w_grant0) begin
        wr_addr <= w_addr0;
        wr_data <= w_data0;
      end
    end
  end

  // Built from registered state only so stall logic sees no input-to-output path.
  always_comb begin
    pending_mask = '0;
    for (int a = 0; a < NREG; a++) begin
      pending_mask[a] = (w_full0 && (w_addr0 == ADDR_W'(a))) ||
                        (w_full1 && (w_addr1 == ADDR_W'(a))) ||
                        (wr_en   && (wr_addr == ADDR_W'(a)));
    end
  end

endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Directed bench for regwrite_port_arbiter: reset, latency, $0 discard,
// starvation override, same-register ordering, hold and mid-flight reset.
module tb_regwrite_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold;
  logic        in0_valid, in0_ready;
  logic [4:0]  in0_addr;
  logic [31:0] in0_data;
  logic        in1_valid, in1_ready;
  logic [4:0]  in1_addr;
  logic [31:0] in1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;

  int errors = 0;
  int checks = 0;

  int s3_a0[7]  = '{10, 11, 12, 13, 14, 15, 15};
  int s3_en[7]  = '{0, 1, 1, 1, 1, 1, 1};
  int s3_wa[7]  = '{0, 10, 11, 12, 13, 3, 14};
  int s3_wd[7]  = '{0, 10, 11, 12, 13, 32'h333, 14};
  int s4_a0[5]  = '{20, 21, 22, 23, 31};
  int s4_d0[5]  = '{32'h20, 32'h21, 32'h22, 32'h23, 32'hA};
  int s4_en[5]  = '{0, 1, 1, 1, 1};
  int s4_wa[5]  = '{0, 20, 21, 22, 23};
  int s4_wd[5]  = '{0, 32'h20, 32'h21, 32'h22, 32'h23};

  regwrite_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int en, input int a, input int d);
    check({tag, ".en"}, 32'(wr_en), en);
    if (en != 0) begin
      check({tag, ".addr"}, 32'(wr_addr), a);
      check({tag, ".data"}, wr_data, d);
    end
  endtask

  task automatic drv(input int v0, input int a0, input int d0,
                     input int v1, input int a1, input int d1, input int h);
    in0_valid = 1'(v0);
    in0_addr  = 5'(a0);
    in0_data  = 32'(d0);
    in1_valid = 1'(v1);
    in1_addr  = 5'(a1);
    in1_data  = 32'(d1);
    hold      = 1'(h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.wr_en", 32'(wr_en), 0);
    check("rst.wr_addr", 32'(wr_addr), 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.mask", pending_mask, 0);
    drv(1, 4, 1, 1, 4, 1, 0);
    #1;
    check("rst.rdy0", 32'(in0_ready), 0);
    check("rst.rdy1", 32'(in1_ready), 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, two cycles from accept to port
    drv(1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
    #1 check("s1.rdy0", 32'(in0_ready), 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk_wr("s1.c1", 0, 0, 0);
    check("s1.mask1", pending_mask, 32'h100);
    @(negedge clk);
    chk_wr("s1.c2", 1, 8, 32'hDEADBEEF);
    check("s1.mask2", pending_mask, 32'h100);
    @(negedge clk);
    chk_wr("s1.c3", 0, 0, 0);
    check("s1.mask3", pending_mask, 0);

    // $0 write accepted and dropped
    drv(1, 0, 32'h1234, 0, 0, 0, 0);
    #1 check("s2.rdy0", 32'(in0_ready), 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk_wr("s2.c1", 0, 0, 0);
    check("s2.mask1", pending_mask, 0);
    @(negedge clk);
    chk_wr("s2.c2", 0, 0, 0);
    check("s2.mask2", pending_mask, 0);

    // starvation override for slot 1
    for (int k = 0; k < 7; k++) begin
      drv(1, s3_a0[k], s3_a0[k], (k == 0) ? 1 : 0, 3, 32'h333, 0);
      if (k == 5) begin
        #1 check("s3.rdy0_blocked", 32'(in0_ready), 0);
      end
      @(negedge clk);
      chk_wr($sformatf("s3.k%0d", k), s3_en[k], s3_wa[k], s3_wd[k]);
      if (k == 4) check("s3.starve_sat", 32'(dut.r_starve), 4);
      if (k == 5) check("s3.starve_clr", 32'(dut.r_starve), 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_wr("s3.drain", 1, 15, 15);
    @(negedge clk);
    chk_wr("s3.idle", 0, 0, 0);

    // same destination: slot 0 first even when starved
    for (int k = 0; k < 5; k++) begin
      drv(1, s4_a0[k], s4_d0[k], (k == 0) ? 1 : 0, 31, 32'hB, 0);
      @(negedge clk);
      chk_wr($sformatf("s4.k%0d", k), s4_en[k], s4_wa[k], s4_wd[k]);
    end
    check("s4.starve_sat", 32'(dut.r_starve), 4);
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_wr("s4.first", 1, 31, 32'hA);
    check("s4.starve_hold", 32'(dut.r_starve), 4);
    @(negedge clk);
    chk_wr("s4.second", 1, 31, 32'hB);
    check("s4.starve_clr", 32'(dut.r_starve), 0);
    @(negedge clk);
    chk_wr("s4.idle", 0, 0, 0);

    // hold with both slots full
    drv(1, 5, 32'h55, 1, 6, 32'h66, 0);
    @(negedge clk);
    chk_wr("s5.fill", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 5, 32'hBAD0, 1, 6, 32'hBAD1, 1);
      #1;
      check($sformatf("s5.h%0d.rdy0", i), 32'(in0_ready), 0);
      check($sformatf("s5.h%0d.rdy1", i), 32'(in1_ready), 0);
      @(negedge clk);
      chk_wr($sformatf("s5.h%0d", i), 0, 0, 0);
      check($sformatf("s5.h%0d.mask", i), pending_mask, 32'h60);
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_wr("s5.rel0", 1, 5, 32'h55);
    @(negedge clk);
    chk_wr("s5.rel1", 1, 6, 32'h66);
    @(negedge clk);
    chk_wr("s5.idle", 0, 0, 0);

    // reset while a write is on the port and both slots are full
    drv(1, 7, 32'h77, 1, 9, 32'h99, 0);
    @(negedge clk);
    drv(1, 12, 32'hCC, 0, 0, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk_wr("s6.pre", 1, 7, 32'h77);
    check("s6.pre_mask", pending_mask, 32'h1280);
    rst_n = 1'b0;
    #1;
    check("s6.rst.wr_en", 32'(wr_en), 0);
    check("s6.rst.wr_addr", 32'(wr_addr), 0);
    check("s6.rst.mask", pending_mask, 0);
    check("s6.rst.rdy0", 32'(in0_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_wr($sformatf("s6.post%0d", i), 0, 0, 0);
      check($sformatf("s6.post%0d.mask", i), pending_mask, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
